// File: rtl/cdf_ctrl_pkg.sv
// Shared types and defaults for the histogram-equalization frame sequencer.
// The ERROR state exists only when CDF_CTRL_TIMEOUT_EN is defined.
package cdf_ctrl_pkg;

    localparam int CDF_W_DEF        = 20;
    localparam int FRAME_CNT_W_DEF  = 16;
    localparam int DRAIN_CYCLES_DEF = 3;

`ifdef CDF_CTRL_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_HIST, ST_CDF, ST_DRAIN, ST_MAP, ST_DONE, ST_ERROR
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_HIST, ST_CDF, ST_DRAIN, ST_MAP, ST_DONE
    } state_e;
`endif

    // Phases that wait on a downstream engine and are covered by the watchdog.
    function automatic logic is_phase(state_e s);
        return (s == ST_HIST) || (s == ST_CDF) || (s == ST_DRAIN) || (s == ST_MAP);
    endfunction

endpackage

// File: rtl/cdf_ctrl_phase_watchdog.sv
// Per-phase watchdog: counts cycles spent in a phase and flags expiry.
// Instantiated by cdf_ctrl only when CDF_CTRL_TIMEOUT_EN is defined.
module cdf_phase_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expire_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cdf_ctrl.sv
// Frame sequencer: histogram build -> CDF pipeline -> drain -> pixel remap.
// Optional per-phase watchdog and ERROR state via `define CDF_CTRL_TIMEOUT_EN.
module cdf_ctrl
    import cdf_ctrl_pkg::*;
#(
    parameter int CDF_W          = CDF_W_DEF,
    parameter int DRAIN_CYCLES   = DRAIN_CYCLES_DEF,
    parameter int FRAME_CNT_W    = FRAME_CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   frame_start,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   hist_start,
    input  logic                   hist_done,
    output logic                   cdf_start,
    input  logic                   cdf_done,
    input  logic                   cdf_valid,
    input  logic [CDF_W-1:0]       cdf_min,
    input  logic                   cdf_we,
    output logic                   cdf_base_offset,
    output logic                   map_start,
    output logic [CDF_W-1:0]       map_cdf_min,
    input  logic                   map_done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   error
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    state_e                 state_q, state_d;
    logic [DRAIN_W-1:0]     drain_q, drain_d;
    logic                   min_seen_q, min_seen_d;
    logic [CDF_W-1:0]       min_q, min_d;
    logic                   hist_start_q, hist_start_d;
    logic                   cdf_start_q, cdf_start_d;
    logic                   map_start_q, map_start_d;
    logic                   frame_done_q, frame_done_d;
    logic                   busy_q, busy_d;
    logic                   offset_q, offset_d;
    logic [FRAME_CNT_W-1:0] count_q, count_d;
    logic                   entering;

    assign entering = (state_d != state_q);

`ifdef CDF_CTRL_TIMEOUT_EN
    logic wd_expire;
    logic error_q, error_d;

    cdf_phase_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear_i  (entering),
        .enable_i (is_phase(state_q)),
        .expire_o (wd_expire)
    );

    assign error_d = (state_d == ST_ERROR);
    assign error   = error_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            drain_q      <= '0;
            min_seen_q   <= 1'b0;
            min_q        <= '0;
            hist_start_q <= 1'b0;
            cdf_start_q  <= 1'b0;
            map_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            offset_q     <= 1'b0;
            count_q      <= '0;
`ifdef CDF_CTRL_TIMEOUT_EN
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            min_seen_q   <= min_seen_d;
            min_q        <= min_d;
            hist_start_q <= hist_start_d;
            cdf_start_q  <= cdf_start_d;
            map_start_q  <= map_start_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            offset_q     <= offset_d;
            count_q      <= count_d;
`ifdef CDF_CTRL_TIMEOUT_EN
            error_q      <= error_d;
`endif
        end
    end

    // A start pulse is still high on a phase's first cycle, which masks a done arriving with it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (frame_start) state_d = ST_HIST;
            ST_HIST:  if (hist_done && !hist_start_q) state_d = ST_CDF;
            ST_CDF:   if (cdf_done && !cdf_start_q) state_d = ST_DRAIN;
            ST_DRAIN: if (!cdf_we && (drain_q == DRAIN_W'(DRAIN_CYCLES - 1))) state_d = ST_MAP;
            ST_MAP:   if (map_done && !map_start_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
`ifdef CDF_CTRL_TIMEOUT_EN
            ST_ERROR: if (frame_start) state_d = ST_IDLE;
`endif
            default:  state_d = ST_IDLE;
        endcase
`ifdef CDF_CTRL_TIMEOUT_EN
        if (wd_expire) state_d = ST_ERROR;
`endif
    end

    always_comb begin
        hist_start_d = entering && (state_d == ST_HIST);
        cdf_start_d  = entering && (state_d == ST_CDF);
        map_start_d  = entering && (state_d == ST_MAP);
        frame_done_d = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
`ifdef CDF_CTRL_TIMEOUT_EN
        busy_d       = busy_d && (state_d != ST_ERROR);
`endif
        drain_d      = (state_q == ST_DRAIN && !cdf_we) ? drain_q + DRAIN_W'(1) : '0;
        min_seen_d   = min_seen_q;
        min_d        = min_q;
        offset_d     = offset_q;
        count_d      = count_q;
        if (cdf_valid && (state_q == ST_CDF || state_q == ST_DRAIN)) begin
            min_seen_d = 1'b1;
            min_d      = cdf_min;
        end
        // No minimum reported this frame: the remap engine must see zero, not last frame's value.
        if (map_start_d && !min_seen_d) begin
            min_d = '0;
        end
        if (entering && state_d == ST_DONE) begin
            count_d    = count_q + FRAME_CNT_W'(1);
            offset_d   = ~offset_q;
            min_seen_d = 1'b0;
        end
    end

    assign busy            = busy_q;
    assign frame_done      = frame_done_q;
    assign hist_start      = hist_start_q;
    assign cdf_start       = cdf_start_q;
    assign map_start       = map_start_q;
    assign map_cdf_min     = min_q;
    assign cdf_base_offset = offset_q;
    assign frame_count     = count_q;

endmodule

// File: doc/cdf_ctrl.md
# cdf_ctrl

Frame-level sequencer for the histogram-equalization datapath. It runs three phases in order: histogram build, CDF pipeline, and pixel remap. It latches the CDF minimum for the remap engine and ping-pongs the scratchpad bank offset between frames. It sits above the histogram engine, the CDF pipeline top and the remap engine, and is the only block that issues their start pulses.

## Interface
Parameters:
- CDF_W, 20, width of CDF values and of the latched minimum
- DRAIN_CYCLES, 3, consecutive cycles with cdf_we low required before the CDF phase is complete
- FRAME_CNT_W, 16, width of the frame counter
- TIMEOUT_CYCLES, 65535, per-phase watchdog limit (used only with CDF_CTRL_TIMEOUT_EN)

Ports:
- clock  in  1  single clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  request one frame; sampled only in IDLE and ERROR
- busy  out  1  high in every state except IDLE and ERROR
- frame_done  out  1  one-cycle pulse when a frame completes
- hist_start  out  1  one-cycle start pulse to the histogram engine
- hist_done  in  1  histogram engine completion pulse
- cdf_start  out  1  one-cycle start pulse to the CDF pipeline
- cdf_done  in  1  CDF fetch-stage done
- cdf_valid  in  1  CDF minimum valid strobe
- cdf_min  in  CDF_W  CDF minimum value
- cdf_we  in  1  CDF store-stage write enable (monitor only)
- cdf_base_offset  out  1  scratchpad bank select driven to the CDF pipeline and the histogram engine
- map_start  out  1  one-cycle start pulse to the remap engine
- map_cdf_min  out  CDF_W  latched CDF minimum; stable for the whole MAP phase
- map_done  in  1  remap engine completion pulse
- frame_count  out  FRAME_CNT_W  number of completed frames; wraps modulo 2^FRAME_CNT_W
- error  out  1  sticky watchdog error flag

## Operation
- States: IDLE, HIST, CDF, DRAIN, MAP, DONE, plus ERROR when the macro is defined.
- IDLE
  - frame_start=1 moves to HIST.
  - hist_start pulses on the first cycle in HIST.
- HIST: hist_done moves to CDF; cdf_start pulses on the first cycle in CDF.
- CDF
  - cdf_valid=1 latches cdf_min into map_cdf_min and sets an internal min_seen flag.
  - Latching on cdf_valid also applies in DRAIN.
  - cdf_done moves to DRAIN.
- DRAIN
  - A counter counts consecutive cycles with cdf_we=0.
  - The counter clears to 0 whenever cdf_we=1.
  - When the count reaches DRAIN_CYCLES, move to MAP.
- MAP
  - map_start pulses on the first cycle in MAP.
  - If min_seen=0 on entry, map_cdf_min is forced to 0.
  - map_done moves to DONE.
- DONE (one cycle), then IDLE:
  - frame_done=1
  - frame_count increments
  - cdf_base_offset toggles
  - min_seen clears
- Done/valid inputs are ignored outside their own phase.
- frame_start is ignored while busy. It is not queued.
- A done input arriving in the same cycle as its start pulse is ignored. Done inputs are sampled only from the second cycle of a phase onward.
- cdf_valid and cdf_done in the same cycle: the minimum is latched and the state moves to DRAIN.
- Reset mid-operation: return to IDLE immediately and clear all registers. The downstream engines are reset by the same reset_n.

## Timing
- Reset values: busy 0, every start pulse 0, frame_done 0, cdf_base_offset 0, map_cdf_min 0, frame_count 0, error 0.
- All outputs are registered.
- frame_start accepted at cycle t gives hist_start=1 at t+1.
- hist_done at t gives cdf_start=1 at t+1.
- DRAIN with cdf_we already low completes after DRAIN_CYCLES cycles. map_start asserts on the following cycle.
- map_done at t gives frame_done=1 at t+1. busy falls at t+2.
- Minimum frame overhead beyond engine latencies: DRAIN_CYCLES+5 cycles.

## Configuration
- CDF_CTRL_TIMEOUT_EN defined:
  - A per-phase counter clears on entry to HIST, CDF, DRAIN and MAP.
  - Reaching TIMEOUT_CYCLES in any of those states moves to ERROR and sets error=1.
  - In ERROR, busy=0 and no start pulses are issued.
  - frame_start in ERROR clears error, moves to IDLE and does not start a frame.
- Not defined: no ERROR state and no counter; error is tied to 0.

## Structure
- Shared package cdf_ctrl_pkg holds:
  - the state enum
  - CDF_W and FRAME_CNT_W defaults
  - the DRAIN_CYCLES default
- Sub-module cdf_phase_watchdog: the counter and compare, with clear and expire ports. It is instantiated only under CDF_CTRL_TIMEOUT_EN.
- The drain counter stays inline.

## Test plan
- Nominal frame: frame_start; hist_done 10 cycles later; cdf_valid with cdf_min=0x00123, then cdf_done; cdf_we low; map_done 8 cycles later -> exactly one pulse each of hist_start, cdf_start and map_start; map_cdf_min=0x00123; frame_done once; frame_count=1; cdf_base_offset=1.
- Drain hold-off: cdf_we high for 4 cycles after cdf_done, with DRAIN_CYCLES=3 -> map_start asserts 4 cycles after cdf_we falls (3 drain cycles plus 1), never earlier.
- No minimum: cdf_done without cdf_valid -> map_cdf_min=0 at map_start.
- Ignored inputs: frame_start pulsed in HIST and in MAP, and a stray hist_done pulsed during MAP -> no extra start pulses; frame_count increments by exactly 1.
- Reset mid-CDF: reset_n low for 2 cycles during the CDF phase -> all outputs return to their reset values; the next frame_start runs a clean frame with cdf_base_offset=0.
- Watchdog (macro defined, TIMEOUT_CYCLES=16): hist_done withheld -> error=1 after 16 cycles in HIST and busy=0; frame_start then clears error and the state returns to IDLE.
